// File: rtl/cellram_model.sv
// Clock-sampled model of an asynchronous-mode CellularRAM (PSRAM) for board-level tests:
// fixed read latency, minimum write-pulse enforcement, access and violation counters.
module cellram_model #(
   parameter int ADDR_BITS     = 10,
   parameter int ACCESS_CYCLES = 7,
   parameter int WRITE_MIN     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [26:1] MemAdr,
   inout  wire  [15:0] MemDB,
   input  logic        RamCS,
   input  logic        MemOE,
   input  logic        MemWR,
   input  logic        RamLB,
   input  logic        RamUB,
   input  logic        MemAdv,
   input  logic        MemClk,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [7:0]  viol_count,
   output logic [1:0]  o_state
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int CW    = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_READ_DRIVE, S_WRITE} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [ADDR_BITS-1:0] r_rd_addr;
   logic [ADDR_BITS-1:0] r_wr_addr;
   logic [CW-1:0]        r_wait;
   logic [7:0]           r_pulse;
   logic [15:0]          r_wr_data;
   logic                 r_wr_lb;
   logic                 r_wr_ub;
   logic [15:0]          r_mem [0:DEPTH-1];

   logic [ADDR_BITS-1:0] w_addr;
   logic                 w_rd_req, w_wr_req, w_viol, w_addr_chg, w_drive;
   logic                 w_load, w_dec, w_capture, w_commit, w_discard, w_rd_done;
   logic [15:0]          w_rd_data;
   logic [8:0]           w_viol_sum;
   logic                 w_unused;

   // Bus semantics: strobes are active-low and sampled on the rising edge. A request is
   // RamCS low with MemOE low (read) or MemWR low (write); write wins when both are low.
   // The part answers a read only by driving MemDB; there is no handshake back.
   assign w_addr     = MemAdr[ADDR_BITS:1];
   assign w_unused   = ^MemAdr[26:ADDR_BITS+1];
   assign w_rd_req   = !RamCS && !MemOE;
   assign w_wr_req   = !RamCS && !MemWR;
   assign w_viol     = !RamCS && ((!MemOE && !MemWR) || MemAdv || MemClk);
   assign w_addr_chg = (w_addr != r_rd_addr);

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_dec     = 1'b0;
      w_capture = 1'b0;
      w_commit  = 1'b0;
      w_discard = 1'b0;
      w_rd_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_wr_req) begin
               w_next    = S_WRITE;
               w_capture = 1'b1;
            end else if (w_rd_req) begin
               w_next = S_READ_WAIT;
               w_load = 1'b1;
            end
         end
         S_READ_WAIT: begin
            if (!w_rd_req)             w_next = S_IDLE;
            else if (w_addr_chg)       w_load = 1'b1;
            else if (r_wait == '0)     w_next = S_READ_DRIVE;
            else                       w_dec  = 1'b1;
         end
         S_READ_DRIVE: begin
            if (!w_rd_req) begin
               w_next    = S_IDLE;
               w_rd_done = 1'b1;
            end else if (w_addr_chg) begin
               w_next = S_READ_WAIT;
               w_load = 1'b1;
            end
         end
         S_WRITE: begin
            if (w_wr_req) begin
               w_capture = 1'b1;
            end else begin
               w_next = S_IDLE;
               if (r_pulse >= 8'(WRITE_MIN)) w_commit  = 1'b1;
               else                          w_discard = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A discarded short write and a same-cycle strobe violation can both land in one cycle.
   assign w_viol_sum = {1'b0, viol_count} + 9'(w_viol) + 9'(w_discard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_wait     <= '0;
         r_pulse    <= '0;
         r_wr_data  <= '0;
         r_wr_lb    <= 1'b0;
         r_wr_ub    <= 1'b0;
         rd_count   <= '0;
         wr_count   <= '0;
         viol_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_rd_addr <= w_addr;
            r_wait    <= CW'(ACCESS_CYCLES - 1);
         end else if (w_dec) begin
            r_wait <= r_wait - 1'b1;
         end
         if (w_capture) begin
            r_wr_data <= MemDB;
            r_wr_addr <= w_addr;
            r_wr_lb   <= RamLB;
            r_wr_ub   <= RamUB;
            if (r_state == S_IDLE)     r_pulse <= 8'd1;
            else if (r_pulse != 8'hFF) r_pulse <= r_pulse + 8'd1;
         end else if (w_commit || w_discard) begin
            r_pulse <= '0;
         end
         if (w_rd_done) rd_count <= rd_count + 16'd1;
         if (w_commit)  wr_count <= wr_count + 16'd1;
         viol_count <= w_viol_sum[8] ? 8'hFF : w_viol_sum[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit) begin
         if (!r_wr_lb) r_mem[r_wr_addr][7:0]  <= r_wr_data[7:0];
         if (!r_wr_ub) r_mem[r_wr_addr][15:8] <= r_wr_data[15:8];
      end
   end

   // Drive gating uses the live strobes so the bus is released in the cycle they deassert.
   assign w_drive      = (r_state == S_READ_DRIVE) && !RamCS && !MemOE && MemWR;
   assign w_rd_data    = r_mem[r_rd_addr];
   assign MemDB[7:0]   = (w_drive && !RamLB) ? w_rd_data[7:0]  : 8'hzz;
   assign MemDB[15:8]  = (w_drive && !RamUB) ? w_rd_data[15:8] : 8'hzz;
   assign o_state      = r_state;
endmodule

// File: tb/tb_cellram_model.sv
// Bench for cellram_model: directed scenarios plus randomized traffic checked against
// a byte-lane array model. MemDB is pulled up, so an undriven lane reads as 8'hFF.
module tb_cellram_model;
   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;
   localparam int LAT   = 7;
   localparam int WMIN  = 3;

   logic        clk       = 1'b0;
   logic        rst       = 1'b0;
   logic [26:1] r_adr     = '0;
   logic        r_cs      = 1'b1;
   logic        r_oe      = 1'b1;
   logic        r_wr      = 1'b1;
   logic        r_lb      = 1'b0;
   logic        r_ub      = 1'b0;
   logic        r_adv     = 1'b0;
   logic        r_mclk    = 1'b0;
   logic        r_tb_drv  = 1'b0;
   logic [15:0] r_tb_data = '0;
   tri1  [15:0] w_db;
   logic [15:0] w_rd_count, w_wr_count;
   logic [7:0]  w_viol;
   logic [1:0]  w_unused_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_mem [0:DEPTH-1];
   bit          m_vlo [0:DEPTH-1];
   bit          m_vhi [0:DEPTH-1];
   int          m_rd   = 0;
   int          m_wr   = 0;
   int          m_viol = 0;
   logic [15:0] exp_q[$];

   assign w_db = r_tb_drv ? r_tb_data : 16'hzzzz;

   cellram_model #(.ADDR_BITS(AB), .ACCESS_CYCLES(LAT), .WRITE_MIN(WMIN)) dut (
      .clk(clk), .rst(rst), .MemAdr(r_adr), .MemDB(w_db),
      .RamCS(r_cs), .MemOE(r_oe), .MemWR(r_wr), .RamLB(r_lb), .RamUB(r_ub),
      .MemAdv(r_adv), .MemClk(r_mclk),
      .rd_count(w_rd_count), .wr_count(w_wr_count), .viol_count(w_viol),
      .o_state(w_unused_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // reference model
   function automatic int idx(input logic [26:1] a);
      return int'(a) % DEPTH;
   endfunction

   function automatic logic [7:0] sat8(input int v);
      return (v > 255) ? 8'hFF : 8'(v);
   endfunction

   function automatic void model_write(input logic [26:1] a, input logic [15:0] d,
                                       input logic lb, input logic ub, input int n);
      int i;
      i = idx(a);
      if (n >= WMIN) begin
         m_wr++;
         if (!lb) begin m_mem[i][7:0]  = d[7:0];  m_vlo[i] = 1'b1; end
         if (!ub) begin m_mem[i][15:8] = d[15:8]; m_vhi[i] = 1'b1; end
      end else begin
         m_viol++;
      end
   endfunction

   function automatic logic [15:0] exp_read(input int i, input logic lb, input logic ub);
      logic [15:0] e;
      e = 16'hFFFF;
      if (!lb) e[7:0]  = m_mem[i][7:0];
      if (!ub) e[15:8] = m_mem[i][15:8];
      return e;
   endfunction

   function automatic logic [15:0] exp_mask(input int i, input logic lb, input logic ub);
      logic [15:0] m;
      m = 16'hFFFF;
      if (!lb && !m_vlo[i]) m[7:0]  = 8'h00;
      if (!ub && !m_vhi[i]) m[15:8] = 8'h00;
      return m;
   endfunction

   // driver tasks
   task automatic bus_idle();
      r_cs = 1'b1; r_oe = 1'b1; r_wr = 1'b1; r_lb = 1'b0; r_ub = 1'b0;
      r_adv = 1'b0; r_mclk = 1'b0; r_tb_drv = 1'b0;
   endtask

   task automatic drive_write(input logic [26:1] a, input logic [15:0] d,
                              input logic lb, input logic ub, input int n);
      @(negedge clk);
      r_adr = a; r_cs = 1'b0; r_wr = 1'b0; r_oe = 1'b1; r_lb = lb; r_ub = ub;
      r_tb_drv = 1'b1; r_tb_data = d;
      repeat (n) @(negedge clk);
      bus_idle();
      @(negedge clk);
   endtask

   task automatic drive_read(input logic [26:1] a, input logic lb, input logic ub,
                             output logic [15:0] early, output logic [15:0] data,
                             output logic [15:0] released);
      @(negedge clk);
      r_adr = a; r_cs = 1'b0; r_oe = 1'b0; r_wr = 1'b1; r_lb = lb; r_ub = ub;
      repeat (LAT) @(negedge clk);
      early = w_db;
      @(negedge clk);
      data = w_db;
      bus_idle();
      #1 released = w_db;
      @(negedge clk);
   endtask

   // scenarios
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if (w_rd_count !== 16'h0 || w_wr_count !== 16'h0 || w_viol !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_counts: rd=%h wr=%h viol=%h required 0/0/0", w_rd_count, w_wr_count, w_viol);
      end
      n_tests++;
      if (w_db !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL reset_bus: MemDB=%h required ffff (undriven)", w_db);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [15:0] early, data, rel, e;
      drive_write(26'd5, 16'hBEEF, 1'b0, 1'b0, 4);
      model_write(26'd5, 16'hBEEF, 1'b0, 1'b0, 4);
      exp_q.push_back(exp_read(idx(26'd5), 1'b0, 1'b0));
      drive_read(26'd5, 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (early !== 16'hFFFF) begin
         n_fail++; $display("FAIL basic_early: MemDB=%h one cycle before latency, required ffff", early);
      end
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL basic_data: MemDB=%h required %h", data, e);
      end
      n_tests++;
      if (rel !== 16'hFFFF) begin
         n_fail++; $display("FAIL basic_release: MemDB=%h after OE high, required ffff", rel);
      end
      n_tests++;
      if (w_wr_count !== 16'(m_wr) || w_rd_count !== 16'(m_rd)) begin
         n_fail++; $display("FAIL basic_counts: wr=%0d rd=%0d required %0d/%0d", w_wr_count, w_rd_count, m_wr, m_rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [15:0] early, data, rel, e;
      drive_write(26'd9, 16'h1234, 1'b0, 1'b0, WMIN);
      model_write(26'd9, 16'h1234, 1'b0, 1'b0, WMIN);
      drive_write(26'd9, 16'hAB00, 1'b1, 1'b0, 4);
      model_write(26'd9, 16'hAB00, 1'b1, 1'b0, 4);
      exp_q.push_back(exp_read(idx(26'd9), 1'b0, 1'b0));
      drive_read(26'd9, 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL lanes_merge: MemDB=%h required %h", data, e);
      end
      exp_q.push_back(exp_read(idx(26'd9), 1'b0, 1'b1));
      drive_read(26'd9, 1'b0, 1'b1, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL lanes_lower_only: MemDB=%h required %h (upper lane undriven)", data, e);
      end
   endtask

   task automatic test_short_write();
      logic [15:0] early, data, rel, e;
      drive_write(26'd3, 16'h5A5A, 1'b0, 1'b0, 4);
      model_write(26'd3, 16'h5A5A, 1'b0, 1'b0, 4);
      drive_write(26'd3, 16'h0000, 1'b0, 1'b0, WMIN - 1);
      model_write(26'd3, 16'h0000, 1'b0, 1'b0, WMIN - 1);
      n_tests++;
      if (w_viol !== sat8(m_viol) || w_wr_count !== 16'(m_wr)) begin
         n_fail++; $display("FAIL short_counts: viol=%0d wr=%0d required %0d/%0d", w_viol, w_wr_count, sat8(m_viol), m_wr);
      end
      exp_q.push_back(exp_read(idx(26'd3), 1'b0, 1'b0));
      drive_read(26'd3, 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL short_array: MemDB=%h required %h", data, e);
      end
   endtask

   task automatic test_addr_change();
      logic [15:0] early, data, rel, e;
      drive_write(26'd1, 16'h5A01, 1'b0, 1'b0, 3);
      model_write(26'd1, 16'h5A01, 1'b0, 1'b0, 3);
      drive_write(26'd2, 16'h0C35, 1'b0, 1'b0, 3);
      model_write(26'd2, 16'h0C35, 1'b0, 1'b0, 3);
      exp_q.push_back(exp_read(idx(26'd2), 1'b0, 1'b0));
      @(negedge clk);
      r_adr = 26'd1; r_cs = 1'b0; r_oe = 1'b0; r_wr = 1'b1; r_lb = 1'b0; r_ub = 1'b0;
      repeat (4) @(negedge clk);
      r_adr = 26'd2;
      repeat (LAT) @(negedge clk);
      early = w_db;
      @(negedge clk);
      data = w_db;
      bus_idle();
      @(negedge clk);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (early !== 16'hFFFF) begin
         n_fail++; $display("FAIL addr_change_early: MemDB=%h required ffff", early);
      end
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL addr_change_data: MemDB=%h required %h", data, e);
      end
      exp_q.push_back(exp_read(idx(26'(DEPTH + 1)), 1'b0, 1'b0));
      drive_read(26'(DEPTH + 1), 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL addr_alias: MemDB=%h required %h", data, e);
      end
   endtask

   task automatic test_violations();
      @(negedge clk);
      r_adr = 26'd50; r_cs = 1'b0; r_oe = 1'b0; r_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (w_db !== 16'hFFFF) begin
            n_fail++; $display("FAIL oe_wr_bus: MemDB=%h cycle %0d required ffff", w_db, i);
         end
      end
      bus_idle();
      @(negedge clk);
      m_viol += 3;
      m_wr++;
      n_tests++;
      if (w_viol !== sat8(m_viol) || w_wr_count !== 16'(m_wr)) begin
         n_fail++; $display("FAIL oe_wr_counts: viol=%0d wr=%0d required %0d/%0d", w_viol, w_wr_count, sat8(m_viol), m_wr);
      end
      r_cs = 1'b0; r_mclk = 1'b1;
      repeat (2) @(negedge clk);
      bus_idle();
      m_viol += 2;
      n_tests++;
      if (w_viol !== sat8(m_viol)) begin
         n_fail++; $display("FAIL memclk_viol: viol=%0d required %0d", w_viol, sat8(m_viol));
      end
      r_cs = 1'b0; r_adv = 1'b1;
      repeat (10) @(negedge clk);
      m_viol += 10;
      n_tests++;
      if (w_viol !== sat8(m_viol)) begin
         n_fail++; $display("FAIL adv_viol: viol=%0d required %0d", w_viol, sat8(m_viol));
      end
      repeat (260) @(negedge clk);
      m_viol += 260;
      bus_idle();
      n_tests++;
      if (w_viol !== 8'hFF) begin
         n_fail++; $display("FAIL viol_saturate: viol=%0d required 255", w_viol);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [15:0] early, data, rel, e;
      @(negedge clk);
      r_adr = 26'd5; r_cs = 1'b0; r_oe = 1'b0; r_wr = 1'b1; r_lb = 1'b0; r_ub = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      n_tests++;
      if (w_db !== m_mem[5]) begin
         n_fail++; $display("FAIL rst_pre_drive: MemDB=%h required %h", w_db, m_mem[5]);
      end
      #2 rst = 1'b1;
      #1;
      m_rd = 0; m_wr = 0; m_viol = 0;
      n_tests++;
      if (w_db !== 16'hFFFF) begin
         n_fail++; $display("FAIL rst_read_release: MemDB=%h required ffff", w_db);
      end
      n_tests++;
      if (w_rd_count !== 16'h0 || w_wr_count !== 16'h0 || w_viol !== 8'h0) begin
         n_fail++; $display("FAIL rst_read_counts: rd=%h wr=%h viol=%h required 0", w_rd_count, w_wr_count, w_viol);
      end
      bus_idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      r_adr = 26'd9; r_cs = 1'b0; r_wr = 1'b0; r_lb = 1'b0; r_ub = 1'b0;
      r_tb_drv = 1'b1; r_tb_data = 16'h7777;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      bus_idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (w_wr_count !== 16'h0 || w_viol !== 8'h0) begin
         n_fail++; $display("FAIL rst_write_counts: wr=%h viol=%h required 0", w_wr_count, w_viol);
      end
      exp_q.push_back(exp_read(idx(26'd9), 1'b0, 1'b0));
      drive_read(26'd9, 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e) begin
         n_fail++; $display("FAIL rst_write_discard: MemDB=%h required %h", data, e);
      end
      exp_q.push_back(exp_read(idx(26'd5), 1'b0, 1'b0));
      drive_read(26'd5, 1'b0, 1'b0, early, data, rel);
      m_rd++;
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || w_rd_count !== 16'(m_rd)) begin
         n_fail++; $display("FAIL rst_retained: MemDB=%h rd=%0d required %h/%0d", data, w_rd_count, e, m_rd);
      end
   endtask

   task automatic test_random();
      logic [26:1] a;
      logic [15:0] d, early, data, rel, e, m;
      logic        lb, ub;
      int          n, i;
      for (int k = 0; k < 60; k++) begin
         a  = 26'($urandom_range(0, 15) + $urandom_range(0, 3) * DEPTH);
         lb = 1'($urandom_range(0, 1));
         ub = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            d = 16'($urandom);
            n = $urandom_range(1, 5);
            drive_write(a, d, lb, ub, n);
            model_write(a, d, lb, ub, n);
         end else begin
            i = idx(a);
            m = exp_mask(i, lb, ub);
            exp_q.push_back(exp_read(i, lb, ub));
            drive_read(a, lb, ub, early, data, rel);
            m_rd++;
            e = exp_q.pop_front();
            n_tests++;
            if (early !== 16'hFFFF || (data & m) !== (e & m) || rel !== 16'hFFFF) begin
               n_fail++;
               $display("FAIL rand_read: addr=%0d lb=%b ub=%b early=%h data=%h rel=%h required ffff/%h(mask %h)/ffff",
                        i, lb, ub, early, data, rel, e, m);
            end
         end
      end
      n_tests++;
      if (w_wr_count !== 16'(m_wr) || w_rd_count !== 16'(m_rd) || w_viol !== sat8(m_viol)) begin
         n_fail++;
         $display("FAIL rand_counts: wr=%0d rd=%0d viol=%0d required %0d/%0d/%0d",
                  w_wr_count, w_rd_count, w_viol, m_wr, m_rd, sat8(m_viol));
      end
   endtask

   initial begin
      bus_idle();
      #1 rst = 1'b1;
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_short_write();
      test_addr_change();
      test_violations();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
